// File: rtl/frame_fetch_pkg.sv
// Shared types and defaults for the camera framebuffer path (frame_fetch,
// camera_read, framebuffer instance).
// Build option: FRAME_FETCH_SCALE2X_EN selects 2x2 pixel replication on readout.
package frame_fetch_pkg;

    typedef logic [11:0] rgb12_t;

    localparam int unsigned SRC_W_DEF        = 320;
    localparam int unsigned SRC_H_DEF        = 240;
    localparam int unsigned ADDR_W_DEF       = 17;
    localparam int unsigned BRAM_LATENCY_DEF = 2;
    localparam rgb12_t      BORDER_COLOR_DEF = 12'hFFF;

`ifdef FRAME_FETCH_SCALE2X_EN
    localparam int unsigned SCALE = 2;
`else
    localparam int unsigned SCALE = 1;
`endif

    // Video control bits carried alongside the framebuffer read latency
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
        logic in_win;
    } vid_ctl_t;

endpackage

// File: rtl/frame_fetch_pipe_delay.sv
// Fixed-depth shift register with synchronous active-low reset, used to
// align video control bits with the framebuffer read data.
module pipe_delay #(
    parameter int unsigned           WIDTH     = 1,
    parameter int unsigned           DEPTH     = 1,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             pclk_in,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift d through DEPTH stages; reset loads every stage with RESET_VAL
    always_ff @(posedge pclk_in) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/frame_fetch.sv
// VGA-side read stage of the camera framebuffer: turns xvga timing into a
// framebuffer port-B address and returns display-aligned RGB with delayed
// sync/blank. Address is built incrementally (row base + column).
// Build option: FRAME_FETCH_SCALE2X_EN -> each source pixel shown as 2x2.
module frame_fetch
    import frame_fetch_pkg::*;
#(
    parameter int unsigned SRC_W        = SRC_W_DEF,
    parameter int unsigned SRC_H        = SRC_H_DEF,
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned BRAM_LATENCY = BRAM_LATENCY_DEF,
    parameter rgb12_t      BORDER_COLOR = BORDER_COLOR_DEF
) (
    input  logic              clk_65mhz,
    input  logic              rst_n,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              blank_in,
    input  logic [10:0]       x_origin_in,
    input  logic [9:0]        y_origin_in,
    output logic [ADDR_W-1:0] fb_addr_out,
    input  rgb12_t            fb_data_in,
    output rgb12_t            rgb_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              blank_out
);

    localparam logic [11:0]       WIN_W    = 12'(SCALE * SRC_W);
    localparam logic [10:0]       WIN_H    = 11'(SCALE * SRC_H);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(SRC_W * (SRC_H - 1));
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(SRC_W - 1);
    localparam vid_ctl_t CTL_RESET = '{hsync: 1'b0, vsync: 1'b0, blank: 1'b1, in_win: 1'b0};

    logic              vsync_q;
    logic [10:0]       x0;
    logic [9:0]        y0;
    logic [ADDR_W-1:0] row_q, row_cur;
    logic [ADDR_W-1:0] col_q, col_cur, col_nxt;
    logic              line_vwin_q;
    logic              h_win, v_win, in_win;
    logic              line_start, col_start;
    vid_ctl_t          ctl_in, ctl_d;

    // Window test widened by one bit so origin + window size cannot wrap
    always_comb begin
        h_win      = ({1'b0, hcount_in} >= {1'b0, x0}) &&
                     ({1'b0, hcount_in} <  ({1'b0, x0} + WIN_W));
        v_win      = ({1'b0, vcount_in} >= {1'b0, y0}) &&
                     ({1'b0, vcount_in} <  ({1'b0, y0} + WIN_H));
        in_win     = h_win && v_win;
        line_start = (hcount_in == '0);
        col_start  = (hcount_in == x0);
    end

`ifdef FRAME_FETCH_SCALE2X_EN
    logic hphase_q, hphase_cur, hphase_nxt;
    logic vphase_q, vphase_cur;

    // Row/column counters are advanced on every other line/pixel for 2x2 replication.
    // The "_cur" values fold this cycle's restart so the address registered now is correct.
    always_comb begin
        row_cur    = row_q;
        vphase_cur = vphase_q;
        if (line_start) begin
            if (vcount_in == y0) begin
                row_cur    = '0;
                vphase_cur = 1'b0;
            end else if (line_vwin_q) begin
                vphase_cur = ~vphase_q;
                if (vphase_q && (row_q < ROW_LAST)) row_cur = row_q + ROW_STEP;
            end
        end
        col_cur    = col_start ? '0 : col_q;
        hphase_cur = col_start ? 1'b0 : hphase_q;
        col_nxt    = col_cur;
        hphase_nxt = hphase_cur;
        if (in_win) begin
            hphase_nxt = ~hphase_cur;
            if (hphase_cur && (col_cur != COL_LAST)) col_nxt = col_cur + 1'b1;
        end
    end

    // Replication phase registers
    always_ff @(posedge clk_65mhz) begin
        if (!rst_n) begin
            hphase_q <= 1'b0;
            vphase_q <= 1'b0;
        end else begin
            hphase_q <= hphase_nxt;
            vphase_q <= vphase_cur;
        end
    end
`else
    // Row/column counters; "_cur" values fold this cycle's restart so the
    // address registered now already reflects a new line or window start
    always_comb begin
        row_cur = row_q;
        if (line_start) begin
            if (vcount_in == y0)                        row_cur = '0;
            else if (line_vwin_q && (row_q < ROW_LAST)) row_cur = row_q + ROW_STEP;
        end
        col_cur = col_start ? '0 : col_q;
        col_nxt = col_cur;
        if (in_win && (col_cur != COL_LAST)) col_nxt = col_cur + 1'b1;
    end
`endif

    // Origin latch on vsync rise, counters, and registered read address
    always_ff @(posedge clk_65mhz) begin
        if (!rst_n) begin
            vsync_q     <= 1'b0;
            x0          <= '0;
            y0          <= '0;
            row_q       <= '0;
            col_q       <= '0;
            line_vwin_q <= 1'b0;
            fb_addr_out <= '0;
        end else begin
            vsync_q <= vsync_in;
            if (vsync_in && !vsync_q) begin
                x0 <= x_origin_in;
                y0 <= y_origin_in;
            end
            row_q <= row_cur;
            col_q <= col_nxt;
            if (line_start) line_vwin_q <= v_win;
            if (in_win)     fb_addr_out <= row_cur + col_cur;
        end
    end

    assign ctl_in = '{hsync: hsync_in, vsync: vsync_in, blank: blank_in, in_win: in_win};

    pipe_delay #(
        .WIDTH     ($bits(vid_ctl_t)),
        .DEPTH     (BRAM_LATENCY + 1),
        .RESET_VAL (CTL_RESET)
    ) u_ctl_pipe (
        .pclk_in (clk_65mhz),
        .rst_n   (rst_n),
        .d       (ctl_in),
        .q       (ctl_d)
    );

    // Output register: blanking wins, then window data, else border colour
    always_ff @(posedge clk_65mhz) begin
        if (!rst_n) begin
            rgb_out   <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            blank_out <= 1'b1;
        end else begin
            rgb_out   <= ctl_d.blank ? 12'h000 : (ctl_d.in_win ? fb_data_in : BORDER_COLOR);
            hsync_out <= ctl_d.hsync;
            vsync_out <= ctl_d.vsync;
            blank_out <= ctl_d.blank;
        end
    end

endmodule

// File: tb/tb_frame_fetch.sv
// Self-checking bench for frame_fetch: drives a compressed xvga raster,
// models the framebuffer as a 2-cycle read memory, and checks the address
// every cycle and the output pixel stream through a scoreboard queue.
module tb_frame_fetch;

    localparam int LAT = 4;
    localparam int SW  = 320;
    localparam int SH  = 240;
`ifdef FRAME_FETCH_SCALE2X_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        bl;
    } exp_t;

    logic        clk_65mhz = 1'b0;
    logic        rst_n;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        hsync_in, vsync_in, blank_in;
    logic [10:0] x_origin_in;
    logic [9:0]  y_origin_in;
    logic [16:0] fb_addr_out;
    logic [11:0] fb_data_in;
    logic [11:0] rgb_out;
    logic        hsync_out, vsync_out, blank_out;

    always #5 clk_65mhz = ~clk_65mhz;

    frame_fetch #(
        .SRC_W        (320),
        .SRC_H        (240),
        .ADDR_W       (17),
        .BRAM_LATENCY (2),
        .BORDER_COLOR (12'hFFF)
    ) dut (
        .clk_65mhz   (clk_65mhz),
        .rst_n       (rst_n),
        .hcount_in   (hcount_in),
        .vcount_in   (vcount_in),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .blank_in    (blank_in),
        .x_origin_in (x_origin_in),
        .y_origin_in (y_origin_in),
        .fb_addr_out (fb_addr_out),
        .fb_data_in  (fb_data_in),
        .rgb_out     (rgb_out),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .blank_out   (blank_out)
    );

    function automatic logic [11:0] mem_word(input logic [16:0] a);
        logic [16:0] t;
        t = a ^ (a >> 5);
        return t[11:0] + 12'h2B1;
    endfunction

    // Framebuffer port B: two registered read stages
    logic [11:0] bram_d1;
    always @(posedge clk_65mhz) begin
        bram_d1    <= mem_word(fb_addr_out);
        fb_data_in <= bram_d1;
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb[$];
    int          x0m, y0m;
    logic        vs_prev_m;
    logic [16:0] exp_addr;
    logic        rst_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One pixel clock: check what the last edge produced, then drive the next input
    task automatic cyc(input bit rst, input int h, input int v, input bit hs, input bit vs, input bit bl);
        exp_t e;
        bit   win;
        int   a;
        @(posedge clk_65mhz);
        #1;
        if (!rst_prev) begin
            check("rst_rgb",   rgb_out,     0);
            check("rst_blank", blank_out,   1);
            check("rst_addr",  fb_addr_out, 0);
            check("rst_hsync", hsync_out,   0);
            check("rst_vsync", vsync_out,   0);
        end else begin
            check("addr", fb_addr_out, exp_addr);
            if (sb.size() == LAT) begin
                e = sb.pop_front();
                check("rgb",   rgb_out,   e.rgb);
                check("hsync", hsync_out, e.hs);
                check("vsync", vsync_out, e.vs);
                check("blank", blank_out, e.bl);
            end else begin
                check("blank_hold", blank_out, 1);
                check("rgb_hold",   rgb_out,   0);
            end
        end
        rst_n     = rst;
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        hsync_in  = hs;
        vsync_in  = vs;
        blank_in  = bl;
        rst_prev  = rst;
        if (!rst) begin
            sb.delete();
            x0m = 0; y0m = 0; vs_prev_m = 1'b0; exp_addr = '0;
        end else begin
            win = (h >= x0m) && (h < x0m + S*SW) && (v >= y0m) && (v < y0m + S*SH);
            if (win) begin
                a = ((v - y0m) / S) * SW + (h - x0m) / S;
                exp_addr = 17'(a);
            end
            e.rgb = bl ? 12'h000 : (win ? mem_word(exp_addr) : 12'hFFF);
            e.hs  = hs;
            e.vs  = vs;
            e.bl  = bl;
            sb.push_back(e);
            if (vs && !vs_prev_m) begin
                x0m = int'(x_origin_in);
                y0m = int'(y_origin_in);
            end
            vs_prev_m = vs;
        end
    endtask

    task automatic line(input int v, input int hmax, input int blank_from, input bit vs);
        for (int h = 0; h <= hmax; h++)
            cyc(1'b1, h, v, bit'((h % 7) == 3), vs, bit'(h >= blank_from));
    endtask

    initial begin
        rst_n = 1'b0; hcount_in = '0; vcount_in = '0;
        hsync_in = 1'b0; vsync_in = 1'b0; blank_in = 1'b1;
        x_origin_in = '0; y_origin_in = '0;
        rst_prev = 1'b0; x0m = 0; y0m = 0; vs_prev_m = 1'b0; exp_addr = '0;

        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        line(0, 9, 1000, 1'b0);
        // Reset in the middle of a line
        for (int i = 0; i < 3; i++) cyc(1'b0, 10 + i, 0, 1'b0, 1'b0, 1'b0);

        // Frame 1, origin (0,0)
        line(0, 330, 1000, 1'b0);
        cyc(1'b1, 320, 0, 1'b0, 1'b0, 1'b1);
        line(1, 3, 1000, 1'b0);
        line(2, 8, 1000, 1'b0);
        for (int v = 3; v < 239; v++) begin
            if (v == 200) begin
                x_origin_in = 11'd100;
                y_origin_in = 10'd50;
            end
            line(v, 3, 1000, 1'b0);
        end
        line(239, 325, 323, 1'b0);
        line(240, 3, 1000, 1'b0);
        line(300, 5, 1000, 1'b0);
        line(301, 3, 1000, 1'b1);
        line(302, 3, 1000, 1'b0);

        // Frame 2, origin (100,50) latched at the vsync rise above
        for (int v = 0; v < 50; v++) line(v, 3, 2, 1'b0);
        line(50, 110, 1000, 1'b0);
        line(51, 3, 1000, 1'b0);
        line(52, 102, 1000, 1'b0);

        for (int i = 0; i < LAT + 1; i++) cyc(1'b1, 0, 600, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
